fetch_redirect_ctrl: RTL and testbench

Control block on the ID side of the fetch interface: drives the IF stage's `brTaken`, `brOffset`, `jumpEnable` and `freeze` inputs, plus squash controls for the IF/ID and ID/EXE pipeline registers. It converts ID-stage branch/jump decisions into one-cycle redirects. It inserts load-use stall cycles with a counter and holds everything during data-memory stalls. It is the consumer end of the PC/instruction stream that the fetch stage produces.

---
 rtl/fetch_redirect_ctrl.sv | 147 ++++++++++++++
 tb/tb_fetch_redirect_ctrl.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_redirect_ctrl.sv
// ID-side fetch redirect controller: branch/jump redirects, load-use stalls, memory-stall hold.
// Optional FETCH_REDIRECT_PERF_EN adds saturating stallCount/redirectCount outputs.
`ifndef WORD_LEN
`define WORD_LEN 16
`endif

module fetch_redirect_ctrl #(
  parameter int WORD_LEN   = `WORD_LEN,
  parameter int LOAD_STALL = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                idBrTaken,
  input  logic                idJump,
  input  logic [WORD_LEN-1:0] idOffset,
  input  logic [3:0]          idSrc1,
  input  logic [3:0]          idSrc2,
  input  logic                idUseSrc1,
  input  logic                idUseSrc2,
  input  logic                exeMemRead,
  input  logic [3:0]          exeDest,
  input  logic                memStall,
  output logic                brTaken,
  output logic [WORD_LEN-1:0] brOffset,
  output logic                jumpEnable,
  output logic                freeze,
  output logic                flush,
  output logic                bubble
`ifdef FETCH_REDIRECT_PERF_EN
  ,
  output logic [15:0]         stallCount,
  output logic [15:0]         redirectCount
`endif
);

  // state  | meaning
  // RUN    | normal operation, ID decisions evaluated
  // LSTALL | load-use stall, r_lsCnt counts remaining cycles
  // REDIR  | one redirect cycle pending/issuing (r_kind: 1=jump, 0=branch)
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    LSTALL = 2'd1,
    REDIR  = 2'd2
  } state_t;

  localparam logic [1:0] LS_INIT = 2'(LOAD_STALL - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [1:0]          r_lsCnt;
  logic [1:0]          w_lsCnt_nxt;
  logic [WORD_LEN-1:0] r_brOffset;
  logic [WORD_LEN-1:0] w_brOffset_nxt;
  logic                r_kind;
  logic                w_kind_nxt;
  logic                w_hz;
  logic                w_issue;

  assign w_hz = exeMemRead & ((idUseSrc1 & (idSrc1 == exeDest)) |
                              (idUseSrc2 & (idSrc2 == exeDest)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RUN;
      r_lsCnt    <= 2'd0;
      r_brOffset <= '0;
      r_kind     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_lsCnt    <= w_lsCnt_nxt;
      r_brOffset <= w_brOffset_nxt;
      r_kind     <= w_kind_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_lsCnt_nxt    = r_lsCnt;
    w_brOffset_nxt = r_brOffset;
    w_kind_nxt     = r_kind;
    freeze         = 1'b0;
    bubble         = 1'b0;
    flush          = 1'b0;
    brTaken        = 1'b0;
    jumpEnable     = 1'b0;
    w_issue        = 1'b0;
    case (r_state)
      RUN: begin
        if (memStall) begin
          freeze = 1'b1;
        end else if (w_hz) begin
          freeze      = 1'b1;
          bubble      = 1'b1;
          w_lsCnt_nxt = LS_INIT;
          if (LOAD_STALL > 1) w_state_nxt = LSTALL;
        end else if (idJump | idBrTaken) begin
          w_brOffset_nxt = idOffset;
          w_kind_nxt     = idJump;
          w_state_nxt    = REDIR;
        end
      end
      LSTALL: begin
        freeze = 1'b1;
        if (!memStall) begin
          bubble      = 1'b1;
          w_lsCnt_nxt = r_lsCnt - 2'd1;
          if (r_lsCnt <= 2'd1) w_state_nxt = RUN;
        end
      end
      REDIR: begin
        // Redirect waits out memory stalls so IF never sees it alongside freeze.
        if (memStall) begin
          freeze = 1'b1;
        end else begin
          w_issue     = 1'b1;
          bubble      = 1'b1;
          jumpEnable  = r_kind;
          brTaken     = ~r_kind;
          flush       = ~r_kind;
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = RUN;
    endcase
  end

  assign brOffset = r_brOffset;

`ifdef FETCH_REDIRECT_PERF_EN
  logic [15:0] r_stallCount;
  logic [15:0] r_redirectCount;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stallCount    <= 16'd0;
      r_redirectCount <= 16'd0;
    end else begin
      if (freeze && (r_stallCount != 16'hFFFF)) r_stallCount <= r_stallCount + 16'd1;
      if (w_issue && (r_redirectCount != 16'hFFFF)) r_redirectCount <= r_redirectCount + 16'd1;
    end
  end

  assign stallCount    = r_stallCount;
  assign redirectCount = r_redirectCount;
`endif

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Directed self-checking bench for fetch_redirect_ctrl (LOAD_STALL=2).
// Perf-counter scenario is compiled in when FETCH_REDIRECT_PERF_EN is defined.
`timescale 1ns/1ps

module tb_fetch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        idBrTaken, idJump;
  logic [15:0] idOffset;
  logic [3:0]  idSrc1, idSrc2, exeDest;
  logic        idUseSrc1, idUseSrc2, exeMemRead, memStall;
  logic        brTaken, jumpEnable, freeze, flush, bubble;
  logic [15:0] brOffset;
`ifdef FETCH_REDIRECT_PERF_EN
  logic [15:0] stallCount, redirectCount;
`endif

  int vecs = 0;
  int errs = 0;

  // {freeze, bubble, flush, brTaken, jumpEnable}
  logic [4:0] outs;
  assign outs = {freeze, bubble, flush, brTaken, jumpEnable};

  fetch_redirect_ctrl #(.WORD_LEN(16), .LOAD_STALL(2)) dut (
    .clk(clk), .rst(rst),
    .idBrTaken(idBrTaken), .idJump(idJump), .idOffset(idOffset),
    .idSrc1(idSrc1), .idSrc2(idSrc2), .idUseSrc1(idUseSrc1), .idUseSrc2(idUseSrc2),
    .exeMemRead(exeMemRead), .exeDest(exeDest), .memStall(memStall),
    .brTaken(brTaken), .brOffset(brOffset), .jumpEnable(jumpEnable),
    .freeze(freeze), .flush(flush), .bubble(bubble)
`ifdef FETCH_REDIRECT_PERF_EN
    , .stallCount(stallCount), .redirectCount(redirectCount)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    idBrTaken = 0; idJump = 0; idOffset = '0;
    idSrc1 = 0; idSrc2 = 0; idUseSrc1 = 0; idUseSrc2 = 0;
    exeMemRead = 0; exeDest = 0; memStall = 0;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst = 1; tick(); tick(); rst = 0;
    vecs++; if (outs !== 5'b00000) begin errs++; $display("FAIL reset_outs: got %b want %b", outs, 5'b00000); end
    vecs++; if (brOffset !== 16'h0000) begin errs++; $display("FAIL reset_off: got %h want %h", brOffset, 16'h0000); end
    memStall = 1; #1;
    vecs++; if (outs !== 5'b10000) begin errs++; $display("FAIL reset_freeze_follows: got %b want %b", outs, 5'b10000); end
    memStall = 0; #1;
  endtask

  task automatic test_memstall_run;
    memStall = 1; idJump = 1; idOffset = 16'h1234; #1;
    vecs++; if (outs !== 5'b10000) begin errs++; $display("FAIL ms_run_freeze: got %b want %b", outs, 5'b10000); end
    tick(); clear_inputs(); #1;
    vecs++; if (outs !== 5'b00000) begin errs++; $display("FAIL ms_run_nocapture: got %b want %b", outs, 5'b00000); end
    vecs++; if (brOffset !== 16'h0000) begin errs++; $display("FAIL ms_run_off: got %h want %h", brOffset, 16'h0000); end
  endtask

  task automatic test_jump;
    idJump = 1; idOffset = 16'h0040; #1;
    vecs++; if (outs !== 5'b00000) begin errs++; $display("FAIL jump_N: got %b want %b", outs, 5'b00000); end
    tick(); clear_inputs(); #1;
    vecs++; if (outs !== 5'b01001) begin errs++; $display("FAIL jump_N1: got %b want %b", outs, 5'b01001); end
    vecs++; if (brOffset !== 16'h0040) begin errs++; $display("FAIL jump_off: got %h want %h", brOffset, 16'h0040); end
    tick();
    vecs++; if (outs !== 5'b00000) begin errs++; $display("FAIL jump_N2: got %b want %b", outs, 5'b00000); end
    vecs++; if (brOffset !== 16'h0040) begin errs++; $display("FAIL jump_off_hold: got %h want %h", brOffset, 16'h0040); end
  endtask

  task automatic test_branch;
    idBrTaken = 1; idOffset = 16'hFFFC;
    tick(); clear_inputs(); #1;
    vecs++; if (outs !== 5'b01110) begin errs++; $display("FAIL branch_N1: got %b want %b", outs, 5'b01110); end
    vecs++; if (brOffset !== 16'hFFFC) begin errs++; $display("FAIL branch_off: got %h want %h", brOffset, 16'hFFFC); end
    tick();
    vecs++; if (outs !== 5'b00000) begin errs++; $display("FAIL branch_N2: got %b want %b", outs, 5'b00000); end
  endtask

  task automatic test_load_use;
    // No hazard when the matching source is unused or EXE is not a load.
    exeMemRead = 1; exeDest = 7; idSrc1 = 7; idUseSrc1 = 0; #1;
    vecs++; if (outs !== 5'b00000) begin errs++; $display("FAIL lu_unused_src: got %b want %b", outs, 5'b00000); end
    exeMemRead = 0; idUseSrc1 = 1; #1;
    vecs++; if (outs !== 5'b00000) begin errs++; $display("FAIL lu_not_load: got %b want %b", outs, 5'b00000); end
    clear_inputs();
    // Hazard on src1 with a jump waiting in ID: stall 2 cycles, then jump.
    exeMemRead = 1; exeDest = 3; idSrc1 = 3; idUseSrc1 = 1; idJump = 1; idOffset = 16'h0123; #1;
    vecs++; if (outs !== 5'b11000) begin errs++; $display("FAIL lu_c0: got %b want %b", outs, 5'b11000); end
    tick(); exeMemRead = 0; #1;
    vecs++; if (outs !== 5'b11000) begin errs++; $display("FAIL lu_c1: got %b want %b", outs, 5'b11000); end
    tick();
    vecs++; if (outs !== 5'b00000) begin errs++; $display("FAIL lu_c2_release: got %b want %b", outs, 5'b00000); end
    tick(); clear_inputs(); #1;
    vecs++; if (outs !== 5'b01001) begin errs++; $display("FAIL lu_jump_after: got %b want %b", outs, 5'b01001); end
    vecs++; if (brOffset !== 16'h0123) begin errs++; $display("FAIL lu_jump_off: got %h want %h", brOffset, 16'h0123); end
    tick();
    // Hazard on src2 with a memory stall inside the load-use stall.
    exeMemRead = 1; exeDest = 5; idSrc2 = 5; idUseSrc2 = 1; #1;
    vecs++; if (outs !== 5'b11000) begin errs++; $display("FAIL lu2_c0: got %b want %b", outs, 5'b11000); end
    tick(); exeMemRead = 0; memStall = 1; #1;
    vecs++; if (outs !== 5'b10000) begin errs++; $display("FAIL lu2_memstall: got %b want %b", outs, 5'b10000); end
    tick(); memStall = 0; #1;
    vecs++; if (outs !== 5'b11000) begin errs++; $display("FAIL lu2_c1: got %b want %b", outs, 5'b11000); end
    tick();
    vecs++; if (outs !== 5'b00000) begin errs++; $display("FAIL lu2_release: got %b want %b", outs, 5'b00000); end
    clear_inputs();
  endtask

  task automatic test_redirect_memstall;
    idJump = 1; idOffset = 16'h0200;
    tick(); clear_inputs(); memStall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      vecs++; if (outs !== 5'b10000) begin errs++; $display("FAIL redir_ms_cycle%0d: got %b want %b", i, outs, 5'b10000); end
      idJump = 1; idOffset = 16'h0999;
      tick();
    end
    clear_inputs(); #1;
    vecs++; if (outs !== 5'b01001) begin errs++; $display("FAIL redir_ms_issue: got %b want %b", outs, 5'b01001); end
    vecs++; if (brOffset !== 16'h0200) begin errs++; $display("FAIL redir_ms_off: got %h want %h", brOffset, 16'h0200); end
    tick();
    vecs++; if (outs !== 5'b00000) begin errs++; $display("FAIL redir_ms_after: got %b want %b", outs, 5'b00000); end
  endtask

  task automatic test_both;
    idJump = 1; idBrTaken = 1; idOffset = 16'h0055;
    tick(); clear_inputs(); #1;
    vecs++; if (outs !== 5'b01001) begin errs++; $display("FAIL both_jump_wins: got %b want %b", outs, 5'b01001); end
    tick();
  endtask

  task automatic test_rst_redir;
    idBrTaken = 1; idOffset = 16'h0777;
    tick(); clear_inputs(); memStall = 1; rst = 1;
    tick(); rst = 0; memStall = 0; #1;
    vecs++; if (outs !== 5'b00000) begin errs++; $display("FAIL rst_redir_outs: got %b want %b", outs, 5'b00000); end
    vecs++; if (brOffset !== 16'h0000) begin errs++; $display("FAIL rst_redir_off: got %h want %h", brOffset, 16'h0000); end
    tick();
    vecs++; if (outs !== 5'b00000) begin errs++; $display("FAIL rst_redir_after: got %b want %b", outs, 5'b00000); end
  endtask

`ifdef FETCH_REDIRECT_PERF_EN
  task automatic test_perf;
    clear_inputs(); rst = 1; tick(); rst = 0;
    for (int i = 0; i < 3; i++) begin
      idJump = 1; idOffset = 16'(i + 1);
      tick(); clear_inputs(); tick();
    end
    exeMemRead = 1; exeDest = 2; idSrc1 = 2; idUseSrc1 = 1;
    tick(); exeMemRead = 0; tick(); clear_inputs(); tick();
    vecs++; if (redirectCount !== 16'd3) begin errs++; $display("FAIL perf_redirects: got %0d want %0d", redirectCount, 3); end
    vecs++; if (stallCount !== 16'd2) begin errs++; $display("FAIL perf_stalls: got %0d want %0d", stallCount, 2); end
  endtask
`endif

  initial begin
    rst = 1;
    clear_inputs();
    test_reset();
    test_memstall_run();
    test_jump();
    test_branch();
    test_load_use();
    test_redirect_memstall();
    test_both();
    test_rst_redir();
`ifdef FETCH_REDIRECT_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
